rr_decoder_driver: RTL

//   Round-robin arbiter that generates the enable, addr0 and addr1 inputs of the
//   2-to-4 structural decoder. Up to four requesters compete for one decoded

---
 rtl/rr_decoder_driver_pkg.sv | 26 ++
 rtl/rr_decoder_driver_pick4.sv | 26 ++
 rtl/rr_decoder_driver.sv | 88 ++++++++
 3 files changed

// File: rtl/rr_decoder_driver_pkg.sv
// Shared types and constants for the round-robin decoder driver.
// State encodings, index width and default burst length live here.
package rr_decoder_driver_pkg;

  localparam int IDX_W         = 2;
  localparam int NREQ          = 4;
  localparam int DEF_MAX_BURST = 4;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic en;
    logic last;
    idx_t idx;
  } grant_t;

  function automatic idx_t idx_inc(idx_t i);
    return i + idx_t'(1);
  endfunction

endpackage

// File: rtl/rr_decoder_driver_pick4.sv
// Rotating first-set-bit search over four requests.
// Returns the first set index at or above ptr, wrapping mod 4.
module rr_pick4
  import rr_decoder_driver_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  idx_t            ptr,
  output logic            found,
  output idx_t            idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;

  always_comb begin
    dbl   = {req, req};
    rot   = dbl[{1'b0, ptr} +: NREQ];
    found = |rot;
    idx   = ptr;
    // Walk down so the lowest rotated bit wins.
    for (int i = NREQ-1; i >= 0; i--) begin
      if (rot[i]) idx = ptr + idx_t'(i);
    end
  end

endmodule

// File: rtl/rr_decoder_driver.sv
// Round-robin driver for a 2-to-4 decoder: bounded bursts with a
// forced enable-low gap cycle between grants.
module rr_decoder_driver
  import rr_decoder_driver_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int CNT_W     = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  output logic            addr0,
  output logic            addr1,
  output logic            enable,
  output logic            grant_last
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_n;
  idx_t             ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NREQ-1:0]  req_q;
  grant_t           g, g_n;
  logic             found;
  idx_t             pick;

  // Arbitration runs on the registered request so no req->output path exists.
  rr_pick4 u_pick (
    .req   (req_q),
    .ptr   (ptr),
    .found (found),
    .idx   (pick)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    g_n     = g;
    unique case (state)
      ST_IDLE: begin
        g_n.en = found;
        if (found) begin
          g_n.idx = pick;
          cnt_n   = CNT_ONE;
          state_n = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!req_q[g.idx] || cnt == CNT_MAX) begin
          g_n.en  = 1'b0;
          ptr_n   = idx_inc(g.idx);
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // req becomes req_q next cycle, so this predicts next cycle's release.
    g_n.last = g_n.en &&
               (!req[g_n.idx] || cnt_n == CNT_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      cnt   <= '0;
      req_q <= '0;
      g     <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      req_q <= req;
      g     <= g_n;
    end
  end

  assign {addr1, addr0} = g.idx;
  assign enable         = g.en;
  assign grant_last     = g.last;

endmodule
